// File: rtl/branch_update_queue.sv
// Branch update queue: holds in-flight predicted branches in allocation order,
// retires the oldest on resolve, and emits a registered predictor update plus a
// mispredict pulse one cycle later. A mispredict or flush squashes all entries.
module branch_update_queue #(
    parameter int PC_BITS  = 32,
    parameter int DEPTH    = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [PC_BITS-1:0]       alloc_pc,
    input  logic                     alloc_pred_taken,
    output logic                     alloc_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic                     flush,
    output logic                     upd_wr_en,
    output logic [PC_BITS-1:0]       upd_orig_pc,
    output logic                     upd_is_taken,
    output logic                     mispredict,
    output logic [PC_BITS-1:0]       mispredict_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_BITS-1:0]      mispredict_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Saturating increment for the mispredict statistics counter.
    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    // Pointer increment; DEPTH is a power of two so the natural wrap is DEPTH-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic [PC_BITS-1:0] mem_pc   [DEPTH];
    logic               mem_pred [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    // Stage p0: resolve decision taken against the current head entry.
    logic               res_vld_p0;
    logic               mis_p0;
    logic               alloc_fire;
    logic [PC_BITS-1:0] head_pc;
    logic               head_pred;

    // Stage p1: registered predictor update / mispredict outputs.
    logic               vld_p1;
    logic [PC_BITS-1:0] upd_pc_p1;
    logic               upd_taken_p1;
    logic               mis_vld_p1;
    logic [PC_BITS-1:0] mis_pc_p1;
    logic [CNT_BITS-1:0] mis_cnt;

    assign alloc_ready = (count < CNT_W'(DEPTH));
    assign head_pc     = mem_pc[head];
    assign head_pred   = mem_pred[head];

    // Resolve/allocate qualification for this cycle.
    always_comb begin
        res_vld_p0 = resolve_valid && (count != '0);
        mis_p0     = res_vld_p0 && (resolve_taken != head_pred);
        alloc_fire = alloc_valid && alloc_ready && !flush && !mis_p0;
    end

    // Entry storage; contents are never reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            mem_pc[tail]   <= alloc_pc;
            mem_pred[tail] <= alloc_pred_taken;
        end
    end

    // Queue pointers and occupancy; a mispredict or flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush || mis_p0) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (res_vld_p0) head <= ptr_inc(head);
            if (alloc_fire) tail <= ptr_inc(tail);
            case ({alloc_fire, res_vld_p0})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- p0 -> p1 stage boundary ----
    // Registered update strobe and mispredict report; payloads hold when not strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            upd_pc_p1    <= '0;
            upd_taken_p1 <= 1'b0;
            mis_vld_p1   <= 1'b0;
            mis_pc_p1    <= '0;
            mis_cnt      <= '0;
        end else begin
            vld_p1     <= res_vld_p0;
            mis_vld_p1 <= mis_p0;
            if (res_vld_p0) begin
                upd_pc_p1    <= head_pc;
                upd_taken_p1 <= resolve_taken;
            end
            if (mis_p0) begin
                mis_pc_p1 <= head_pc;
                mis_cnt   <= sat_inc(mis_cnt);
            end
        end
    end

    assign upd_wr_en      = vld_p1;
    assign upd_orig_pc    = upd_pc_p1;
    assign upd_is_taken   = upd_taken_p1;
    assign mispredict     = mis_vld_p1;
    assign mispredict_pc  = mis_pc_p1;
    assign mispredict_cnt = mis_cnt;

endmodule

// File: tb/tb_branch_update_queue.sv
// Testbench for branch_update_queue: queue-based reference model, scoreboard of
// expected predictor updates, monitor on the falling edge, directed + random stimulus.
module tb_branch_update_queue;

    localparam int PC_BITS  = 32;
    localparam int DEPTH    = 8;
    localparam int CNT_BITS = 4;

    logic                clk;
    logic                rst;
    logic                alloc_valid;
    logic [PC_BITS-1:0]  alloc_pc;
    logic                alloc_pred_taken;
    logic                alloc_ready;
    logic                resolve_valid;
    logic                resolve_taken;
    logic                flush;
    logic                upd_wr_en;
    logic [PC_BITS-1:0]  upd_orig_pc;
    logic                upd_is_taken;
    logic                mispredict;
    logic [PC_BITS-1:0]  mispredict_pc;
    logic [3:0]          count;
    logic [CNT_BITS-1:0] mispredict_cnt;

    branch_update_queue #(
        .PC_BITS(PC_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_ready(alloc_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .flush(flush),
        .upd_wr_en(upd_wr_en), .upd_orig_pc(upd_orig_pc),
        .upd_is_taken(upd_is_taken),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .count(count), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PC_BITS-1:0] pc;
        logic               pred;
    } ent_t;

    typedef struct {
        logic [PC_BITS-1:0] pc;
        logic               taken;
        logic               mis;
    } upd_t;

    ent_t mq[$];   // in-flight branches, oldest first
    upd_t sb[$];   // expected predictor updates

    logic [PC_BITS-1:0]  m_upc;
    logic                m_ut;
    logic [PC_BITS-1:0]  m_mpc;
    logic [CNT_BITS-1:0] m_mcnt;

    int  n_chk = 0;
    int  n_err = 0;
    bit  mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural behaviour of the queue from its rules.
    always @(posedge clk) begin
        int   sz;
        ent_t e;
        logic mis;
        sz  = mq.size();
        mis = 1'b0;
        if (rst) begin
            mq.delete();
            m_upc  = '0;
            m_ut   = 1'b0;
            m_mpc  = '0;
            m_mcnt = '0;
        end else begin
            if (resolve_valid && sz > 0) begin
                e   = mq.pop_front();
                mis = (e.pred != resolve_taken);
                sb.push_back('{pc: e.pc, taken: resolve_taken, mis: mis});
                m_upc = e.pc;
                m_ut  = resolve_taken;
                if (mis) begin
                    m_mpc = e.pc;
                    if (m_mcnt != {CNT_BITS{1'b1}}) m_mcnt = m_mcnt + 1'b1;
                end
            end
            if (flush || mis)
                mq.delete();
            else if (alloc_valid && sz < DEPTH)
                mq.push_back('{pc: alloc_pc, pred: alloc_pred_taken});
        end
    end

    // Monitor: compare DUT outputs against the scoreboard and model state.
    always @(negedge clk) begin
        upd_t u;
        if (mon_en) begin
            chk("upd_wr_en", {31'b0, upd_wr_en}, {31'b0, (sb.size() > 0)});
            if (sb.size() > 0) begin
                u = sb.pop_front();
                if (upd_wr_en) begin
                    chk("upd_orig_pc", upd_orig_pc, u.pc);
                    chk("upd_is_taken", {31'b0, upd_is_taken}, {31'b0, u.taken});
                end
                chk("mispredict", {31'b0, mispredict}, {31'b0, u.mis});
            end else begin
                chk("mispredict_idle", {31'b0, mispredict}, 32'd0);
            end
            chk("count", {28'b0, count}, mq.size());
            chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, (mq.size() < DEPTH)});
            chk("mispredict_cnt", {28'b0, mispredict_cnt}, {28'b0, m_mcnt});
            chk("upd_orig_pc_hold", upd_orig_pc, m_upc);
            chk("upd_is_taken_hold", {31'b0, upd_is_taken}, {31'b0, m_ut});
            chk("mispredict_pc_hold", mispredict_pc, m_mpc);
        end
    end

    task automatic step(input logic av, input logic [31:0] pc, input logic pt,
                        input logic rv, input logic rt, input logic fl, input logic r);
        alloc_valid      = av;
        alloc_pc         = pc;
        alloc_pred_taken = pt;
        resolve_valid    = rv;
        resolve_taken    = rt;
        flush            = fl;
        rst              = r;
        @(posedge clk);
        #1;
        alloc_valid   = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
    endtask

    function automatic logic head_pred();
        return (mq.size() > 0) ? mq[0].pred : 1'b0;
    endfunction

    initial begin
        alloc_valid = 0; alloc_pc = '0; alloc_pred_taken = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0; rst = 1;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        mon_en = 1;
        chk("rst_count", {28'b0, count}, 32'd0);
        chk("rst_alloc_ready", {31'b0, alloc_ready}, 32'd1);
        chk("rst_upd_wr_en", {31'b0, upd_wr_en}, 32'd0);
        chk("rst_upd_orig_pc", upd_orig_pc, 32'd0);
        chk("rst_mispredict_pc", mispredict_pc, 32'd0);
        chk("rst_mispredict_cnt", {28'b0, mispredict_cnt}, 32'd0);

        // Two branches, both predicted correctly
        step(1, 32'h100, 1, 0, 0, 0, 0);
        step(1, 32'h104, 0, 0, 0, 0, 0);
        chk("basic_count2", {28'b0, count}, 32'd2);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("basic_upd0_pc", upd_orig_pc, 32'h100);
        chk("basic_upd0_t", {31'b0, upd_is_taken}, 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("basic_upd1_pc", upd_orig_pc, 32'h104);
        chk("basic_upd1_t", {31'b0, upd_is_taken}, 32'd0);
        chk("basic_no_mis", {31'b0, mispredict}, 32'd0);
        chk("basic_count0", {28'b0, count}, 32'd0);

        // Fill to DEPTH, overflow attempt, resolve+alloc while full
        for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + 4 * i, 1, 0, 0, 0, 0);
        chk("full_ready", {31'b0, alloc_ready}, 32'd0);
        chk("full_count", {28'b0, count}, DEPTH);
        step(1, 32'h2000, 1, 0, 0, 0, 0);
        chk("full_ignored", {28'b0, count}, DEPTH);
        step(1, 32'h2004, 1, 1, 1, 0, 0);
        chk("full_res_alloc", {28'b0, count}, DEPTH - 1);
        chk("full_res_pc", upd_orig_pc, 32'h1000);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 1, 1, 0, 0);
        chk("drain_last_pc", upd_orig_pc, 32'h1000 + 4 * (DEPTH - 1));
        chk("drain_count", {28'b0, count}, 32'd0);

        // Mispredict squashes wrong-path entries
        step(1, 32'h200, 1, 0, 0, 0, 0);
        step(1, 32'h204, 0, 0, 0, 0, 0);
        step(1, 32'h208, 1, 0, 0, 0, 0);
        step(1, 32'h20c, 1, 1, 0, 0, 0);
        chk("mis_pulse", {31'b0, mispredict}, 32'd1);
        chk("mis_pc", mispredict_pc, 32'h200);
        chk("mis_taken", {31'b0, upd_is_taken}, 32'd0);
        chk("mis_count", {28'b0, count}, 32'd0);
        chk("mis_cnt1", {28'b0, mispredict_cnt}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mis_one_cycle", {31'b0, mispredict}, 32'd0);

        // Continuous alloc+resolve with correct predictions, pointer wrap
        step(1, 32'h300, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h304 + 4 * i, i[0], 1, head_pred(), 0, 0);
            chk("stream_count", {28'b0, count}, 32'd1);
            chk("stream_pc", upd_orig_pc, 32'h300 + 4 * i);
        end
        step(0, 0, 0, 1, head_pred(), 0, 0);
        chk("stream_count0", {28'b0, count}, 32'd0);

        // Flush together with resolve, then resolve on an empty queue
        for (int i = 0; i < 3; i++) step(1, 32'h400 + 4 * i, 1, 0, 0, 0, 0);
        step(1, 32'h40c, 1, 1, 1, 1, 0);
        chk("flush_upd", {31'b0, upd_wr_en}, 32'd1);
        chk("flush_pc", upd_orig_pc, 32'h400);
        chk("flush_count", {28'b0, count}, 32'd0);
        step(1, 32'h500, 1, 1, 0, 0, 0);
        chk("empty_res_no_upd", {31'b0, upd_wr_en}, 32'd0);
        chk("empty_res_no_mis", {31'b0, mispredict}, 32'd0);
        step(0, 0, 0, 1, 1, 0, 0);

        // Saturation of the mispredict counter
        for (int i = 0; i < 18; i++) begin
            step(1, 32'h600 + 4 * i, 1, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0, 0, 0);
        end
        chk("cnt_saturated", {28'b0, mispredict_cnt}, 32'd15);

        // Reset with entries held and resolve pending
        for (int i = 0; i < 4; i++) step(1, 32'h700 + 4 * i, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("rst4_count", {28'b0, count}, 32'd0);
        chk("rst4_ready", {31'b0, alloc_ready}, 32'd1);
        chk("rst4_no_upd", {31'b0, upd_wr_en}, 32'd0);
        chk("rst4_cnt", {28'b0, mispredict_cnt}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst4_no_upd_late", {31'b0, upd_wr_en}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic av, rv, rt, fl, r;
            av = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 5);
            rt = ($urandom_range(0, 5) == 0) ? 1'($urandom) : head_pred();
            fl = ($urandom_range(0, 49) == 0);
            r  = ($urandom_range(0, 399) == 0);
            step(av, $urandom & 32'hffff_fffc, 1'($urandom), rv, rt, fl, r);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 SHALL have parameter PC_BITS, default 32, meaning branch PC width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning in-flight branch entries (power of 2, >=2).
REQ-003 SHALL have parameter CNT_BITS, default 16, meaning mispredict statistics counter width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alloc_valid  input  1  fetch requests allocation of a predicted branch.
REQ-007 SHALL have port alloc_pc  input  PC_BITS  PC of the predicted branch.
REQ-008 SHALL have port alloc_pred_taken  input  1  direction predicted at fetch.
REQ-009 SHALL have port alloc_ready  output  1  queue not full; allocation accepted only when alloc_valid && alloc_ready.
REQ-010 SHALL have port resolve_valid  input  1  oldest in-flight branch resolved this cycle.
REQ-011 SHALL have port resolve_taken  input  1  actual direction of the oldest branch.
REQ-012 SHALL have port flush  input  1  external pipeline flush; discards all entries.
REQ-013 SHALL have port upd_wr_en  output  1  predictor update strobe (drives predictor Wr_En).
REQ-014 SHALL have port upd_orig_pc  output  PC_BITS  PC to update (drives predictor Orig_PC).
REQ-015 SHALL have port upd_is_taken  output  1  actual outcome (drives predictor is_Taken).
REQ-016 SHALL have port mispredict  output  1  one-cycle pulse, resolved direction != predicted.
REQ-017 SHALL have port mispredict_pc  output  PC_BITS  PC of the mispredicted branch.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-019 SHALL have port mispredict_cnt  output  CNT_BITS  saturating mispredict count.

Function
REQ-020 SHALL store {pc, pred_taken} in a circular buffer with head (oldest) and tail pointers; pointers wrap DEPTH-1 -> 0.
REQ-021 SHALL drive alloc_ready = (count < DEPTH), from registered state only; a resolve in the same cycle does not make a full queue ready.
REQ-022 SHALL write the entry at tail and increment tail and count when alloc_valid && alloc_ready && !flush && !(resolve mispredict this cycle).
REQ-023 SHALL ignore resolve_valid when count == 0 (no update, no pulse), including a same-cycle allocation into an empty queue.
REQ-024 SHALL, on resolve_valid with count > 0, pop the head entry and, on the next cycle, assert upd_wr_en=1, upd_orig_pc=head pc, upd_is_taken=resolve_taken (1-cycle registered latency).
REQ-025 SHALL, when resolve_taken != head pred_taken, assert mispredict and mispredict_pc=head pc in the same cycle as upd_wr_en.
REQ-026 SHALL, on a mispredict resolve, discard all remaining (wrong-path) entries: count=0, head=tail, same-cycle alloc dropped.
REQ-027 SHALL, on flush, discard all entries and drop same-cycle allocation; a same-cycle valid resolve is still processed (update and mispredict emitted) before the queue empties.
REQ-028 SHALL handle simultaneous alloc and correct-prediction resolve with count unchanged and both pointers advanced.
REQ-029 SHALL keep upd_wr_en and mispredict low in every cycle not following a valid resolve; upd_orig_pc, upd_is_taken and mispredict_pc hold their last values when not strobed.
REQ-030 SHALL increment mispredict_cnt on each mispredict pulse, saturating at 2^CNT_BITS-1.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, set head=tail=0, count=0, alloc_ready=1, upd_wr_en=0, upd_is_taken=0, upd_orig_pc=0, mispredict=0, mispredict_pc=0, mispredict_cnt=0.
REQ-032 SHALL abort any pending update on reset: a resolve in the reset cycle produces no upd_wr_en afterwards.
REQ-033 SHALL leave entry storage contents unreset; validity is defined by count only.

Verification
REQ-034 Alloc PCs 0x100,0x104 (pred T,N); resolve T then N -> upd_wr_en pulses with 0x100/T and 0x104/N, no mispredict, count 2->0.
REQ-035 Fill DEPTH=8 entries -> alloc_ready=0, 9th alloc ignored; resolve+alloc same cycle when full -> alloc dropped, count 7.
REQ-036 Alloc 0x200(pred T),0x204,0x208; resolve N -> next cycle mispredict=1, mispredict_pc=0x200, upd_is_taken=0, count=0, mispredict_cnt=1.
REQ-037 Allocate/resolve 20 branches continuously with correct predictions -> pointer wrap, count stays 1, updates in allocation order.
REQ-038 Flush with resolve_valid in same cycle on 3 entries -> one update for head pc, count=0; resolve on empty queue -> no upd_wr_en.
REQ-039 Assert rst with 4 entries and resolve_valid high -> count=0, alloc_ready=1, no upd_wr_en next cycle, mispredict_cnt=0.
